// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one single-beat AXI-style memory port.
// IFU (s0) reads, LSU (s1) reads/writes; one transaction in flight, round-robin on conflict.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  // IFU read port
  input  logic                    s0_arvalid,
  output logic                    s0_arready,
  input  logic [ADDR_WIDTH-1:0]   s0_araddr,
  output logic                    s0_rvalid,
  input  logic                    s0_rready,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  output logic [1:0]              s0_rresp,
  // LSU read port
  input  logic                    s1_arvalid,
  output logic                    s1_arready,
  input  logic [ADDR_WIDTH-1:0]   s1_araddr,
  output logic                    s1_rvalid,
  input  logic                    s1_rready,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic [1:0]              s1_rresp,
  // LSU write port
  input  logic                    s1_awvalid,
  input  logic                    s1_wvalid,
  input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
  output logic                    s1_awready,
  output logic                    s1_bvalid,
  input  logic                    s1_bready,
  output logic [1:0]              s1_bresp,
  // downstream memory port
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp,
  output logic                    busy,
  output logic [2:0]              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and payload stays stable while valid is high.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t                  r_state, w_next;
  logic                    r_grant, r_last;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic                    r_awpend, r_wpend;

  logic w_idle, w_s1_wr, w_s1_req, w_pick_s1;
  logic w_acc_s0, w_acc_s1r, w_acc_s1w;

  // Readies are also held low while reset is asserted, since IDLE accepts combinationally.
  assign w_idle    = (r_state == IDLE) & rst;
  assign w_s1_wr   = s1_awvalid & s1_wvalid;
  assign w_s1_req  = s1_arvalid | w_s1_wr;
  assign w_pick_s1 = w_s1_req & (~s0_arvalid | ~r_last);
  assign w_acc_s0  = w_idle & s0_arvalid & ~w_pick_s1;
  assign w_acc_s1r = w_idle & w_pick_s1 & s1_arvalid;
  assign w_acc_s1w = w_idle & w_pick_s1 & ~s1_arvalid & w_s1_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s1_awready = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    s1_bvalid  = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    case (r_state)
      IDLE: begin
        s0_arready = w_acc_s0;
        s1_arready = w_acc_s1r;
        s1_awready = w_acc_s1w;
        if (w_acc_s0 | w_acc_s1r) w_next = RD_ADDR;
        else if (w_acc_s1w)       w_next = WR_REQ;
      end
      RD_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) w_next = RD_DATA;
      end
      RD_DATA: begin
        s0_rvalid = m_rvalid & ~r_grant;
        s1_rvalid = m_rvalid & r_grant;
        m_rready  = r_grant ? s1_rready : s0_rready;
        if (m_rvalid & m_rready) w_next = IDLE;
      end
      WR_REQ: begin
        m_awvalid = r_awpend;
        m_wvalid  = r_wpend;
        // Leave as soon as neither channel still owes a handshake after this edge.
        if (~(r_awpend & ~m_awready) & ~(r_wpend & ~m_wready)) w_next = WR_RESP;
      end
      WR_RESP: begin
        s1_bvalid = m_bvalid;
        m_bready  = s1_bready;
        if (m_bvalid & s1_bready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_awpend <= 1'b0;
      r_wpend  <= 1'b0;
    end else if (w_acc_s0) begin
      r_addr  <= s0_araddr;
      r_grant <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_acc_s1r) begin
      r_addr  <= s1_araddr;
      r_grant <= 1'b1;
      r_last  <= 1'b1;
    end else if (w_acc_s1w) begin
      r_addr   <= s1_awaddr;
      r_wdata  <= s1_wdata;
      r_wstrb  <= s1_wstrb;
      r_grant  <= 1'b1;
      r_last   <= 1'b1;
      r_awpend <= 1'b1;
      r_wpend  <= 1'b1;
    end else if (r_state == WR_REQ) begin
      if (m_awready) r_awpend <= 1'b0;
      if (m_wready)  r_wpend  <= 1'b0;
    end
  end

  assign m_araddr  = r_addr;
  assign m_awaddr  = r_addr;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign s0_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s1_rdata  = m_rdata;
  assign s1_rresp  = m_rresp;
  assign s1_bresp  = m_bresp;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a vector table of arbitration cases plus hand-written
// sequences for write-channel skew, read backpressure and mid-transaction reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s0_arvalid = 0, s0_arready, s0_rvalid, s0_rready = 0;
  logic [31:0] s0_araddr = 0, s0_rdata;
  logic [1:0]  s0_rresp;
  logic        s1_arvalid = 0, s1_arready, s1_rvalid, s1_rready = 0;
  logic [31:0] s1_araddr = 0, s1_rdata;
  logic [1:0]  s1_rresp;
  logic        s1_awvalid = 0, s1_wvalid = 0, s1_awready, s1_bvalid, s1_bready = 0;
  logic [31:0] s1_awaddr = 0, s1_wdata = 0;
  logic [3:0]  s1_wstrb = 0;
  logic [1:0]  s1_bresp;
  logic        m_arvalid, m_arready = 0, m_rvalid = 0, m_rready;
  logic [31:0] m_araddr, m_rdata = 0;
  logic [1:0]  m_rresp = 0;
  logic        m_awvalid, m_awready = 0, m_wvalid, m_wready = 0;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid = 0, m_bready;
  logic [1:0]  m_bresp = 0;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_awvalid(s1_awvalid), .s1_wvalid(s1_wvalid), .s1_awaddr(s1_awaddr),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_awready(s1_awready),
    .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_bresp(s1_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        s0v, s1rv, s1wv;
    logic [31:0] a0, a1, aw, wd;
    logic [3:0]  ws;
    logic [31:0] rd;
    logic [1:0]  resp;
    int          exp_port;  // 0 = s0 read, 1 = s1 read, 2 = s1 write
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Present a request set in IDLE, check which ready fires, record the expected address.
  task automatic issue(input vec_t v);
    s0_arvalid = v.s0v;  s0_araddr = v.a0;
    s1_arvalid = v.s1rv; s1_araddr = v.a1;
    s1_awvalid = v.s1wv; s1_wvalid = v.s1wv;
    s1_awaddr = v.aw; s1_wdata = v.wd; s1_wstrb = v.ws;
    #1;
    chk("s0_arready", s0_arready, v.exp_port == 0);
    chk("s1_arready", s1_arready, v.exp_port == 1);
    chk("s1_awready", s1_awready, v.exp_port == 2);
    exp_q.push_back(v.exp_port == 0 ? v.a0 : (v.exp_port == 1 ? v.a1 : v.aw));
    tick();
    s0_arvalid = 0; s1_arvalid = 0; s1_awvalid = 0; s1_wvalid = 0;
    chk("m_arvalid_lat1", m_arvalid, v.exp_port < 2);
    chk("m_awvalid_lat1", m_awvalid, v.exp_port == 2);
  endtask

  task automatic serve_addr();
    int n = 0;
    while (!m_arvalid && n < 8) begin tick(); n++; end
    chk("m_arvalid_wait", m_arvalid, 1'b1);
    if (exp_q.size() == 0) chk("exp_q_empty", 32'd0, 32'd1);
    else chk("m_araddr", m_araddr, exp_q.pop_front());
    m_arready = 1;
    tick();
    m_arready = 0;
    chk("state_rd_data", dbg_state, 3'd2);
  endtask

  task automatic serve_data(input int port, input logic [31:0] rd, input logic [1:0] resp);
    s0_rready = (port == 0); s1_rready = (port == 1);
    m_rvalid = 1; m_rdata = rd; m_rresp = resp;
    #1;
    chk("s0_rvalid", s0_rvalid, port == 0);
    chk("s1_rvalid", s1_rvalid, port == 1);
    chk("rdata", port == 0 ? s0_rdata : s1_rdata, rd);
    chk("rresp", port == 0 ? s0_rresp : s1_rresp, resp);
    chk("m_rready", m_rready, 1'b1);
    tick();
    m_rvalid = 0; s0_rready = 0; s1_rready = 0;
    chk("busy_after_read", busy, 1'b0);
  endtask

  task automatic serve_bresp(input logic [1:0] resp);
    chk("state_wr_resp", dbg_state, 3'd4);
    m_bvalid = 1; m_bresp = resp; s1_bready = 1;
    #1;
    chk("s1_bvalid", s1_bvalid, 1'b1);
    chk("s1_bresp", s1_bresp, resp);
    chk("m_bready", m_bready, 1'b1);
    tick();
    m_bvalid = 0; s1_bready = 0;
    chk("busy_after_write", busy, 1'b0);
  endtask

  task automatic serve_write(input logic [31:0] wd, input logic [3:0] ws, input logic [1:0] resp);
    chk("m_wvalid", m_wvalid, 1'b1);
    if (exp_q.size() == 0) chk("exp_q_empty", 32'd0, 32'd1);
    else chk("m_awaddr", m_awaddr, exp_q.pop_front());
    chk("m_wdata", m_wdata, wd);
    chk("m_wstrb", m_wstrb, ws);
    m_awready = 1; m_wready = 1;
    tick();
    m_awready = 0; m_wready = 0;
    serve_bresp(resp);
  endtask

  initial begin
    vec_t v;
    // exp_port follows round-robin from reset (last = s1, so s0 wins the first conflict)
    vecs[0] = '{1, 0, 0, 32'h0000_1000, 32'h0, 32'h0, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'd0, 0};
    vecs[1] = '{1, 1, 0, 32'h0000_0100, 32'h0000_0200, 32'h0, 32'h0, 4'h0, 32'h0, 2'd0, 1};
    vecs[2] = '{1, 1, 0, 32'h0000_0104, 32'h0000_0204, 32'h0, 32'h0, 4'h0, 32'h0, 2'd1, 0};
    vecs[3] = '{1, 1, 0, 32'h0000_0108, 32'h0000_0208, 32'h0, 32'h0, 4'h0, 32'h0, 2'd0, 1};
    vecs[4] = '{0, 1, 1, 32'h0, 32'h0000_0300, 32'h0000_0400, 32'hA5A5_0001, 4'hF, 32'h0, 2'd0, 1};
    vecs[5] = '{0, 0, 1, 32'h0, 32'h0, 32'h0000_0400, 32'hA5A5_0001, 4'hF, 32'h0, 2'd0, 2};
    vecs[6] = '{1, 0, 1, 32'h0000_0500, 32'h0, 32'h0000_0600, 32'h1111_2222, 4'h1, 32'h0, 2'd0, 0};
    vecs[7] = '{1, 0, 1, 32'h0000_0504, 32'h0, 32'h0000_0604, 32'h3333_4444, 4'hC, 32'h0, 2'd2, 2};
    vecs[8] = '{0, 1, 0, 32'h0, 32'h0000_0700, 32'h0, 32'h0, 4'h0, 32'h0, 2'd3, 1};
    for (int i = 1; i < 9; i++) vecs[i].rd = $urandom();

    // reset state, with a request pending to show readies stay low
    s0_arvalid = 1;
    #12;
    chk("rst_s0_arready", s0_arready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_arvalid", m_arvalid, 1'b0);
    chk("rst_m_awvalid", m_awvalid, 1'b0);
    s0_arvalid = 0;
    tick();
    rst = 1;
    tick();

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i]);
      if (vecs[i].exp_port < 2) begin
        serve_addr();
        serve_data(vecs[i].exp_port, vecs[i].rd, vecs[i].resp);
      end else begin
        serve_write(vecs[i].wd, vecs[i].ws, vecs[i].resp);
      end
      tick();
    end

    // write with m_wready three cycles ahead of m_awready, SLVERR response
    v = '{0, 0, 1, 32'h0, 32'h0, 32'h0000_2000, 32'h1234_5678, 4'h3, 32'h0, 2'd2, 2};
    issue(v);
    chk("skew_m_wdata", m_wdata, 32'h1234_5678);
    chk("skew_m_wstrb", m_wstrb, 4'h3);
    m_wready = 1;
    tick();
    m_wready = 0;
    chk("skew_wvalid_drop", m_wvalid, 1'b0);
    chk("skew_awvalid_hold", m_awvalid, 1'b1);
    tick();
    tick();
    chk("skew_still_wr_req", dbg_state, 3'd3);
    chk("skew_m_awaddr", m_awaddr, exp_q.size() ? exp_q.pop_front() : 32'hFFFF_FFFF);
    m_awready = 1;
    tick();
    m_awready = 0;
    chk("skew_awvalid_drop", m_awvalid, 1'b0);
    serve_bresp(2'd2);
    tick();

    // read-data backpressure with a competing s1 request
    v = '{1, 0, 0, 32'h0000_3000, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 2'd0, 0};
    issue(v);
    serve_addr();
    m_rvalid = 1; m_rdata = 32'hCAFE_F00D; s0_rready = 0;
    s1_arvalid = 1; s1_araddr = 32'h0000_3100;
    for (int c = 0; c < 5; c++) begin
      chk("bp_m_rready", m_rready, 1'b0);
      chk("bp_s1_arready", s1_arready, 1'b0);
      chk("bp_busy", busy, 1'b1);
      tick();
    end
    s0_rready = 1;
    #1;
    chk("bp_release_m_rready", m_rready, 1'b1);
    tick();
    m_rvalid = 0; s0_rready = 0;
    chk("bp_s1_arready_idle", s1_arready, 1'b1);
    exp_q.push_back(32'h0000_3100);
    tick();
    s1_arvalid = 0;
    serve_addr();
    serve_data(1, 32'h0BAD_C0DE, 2'd0);
    tick();

    // asynchronous reset while in RD_DATA
    v = '{1, 0, 0, 32'h0000_4000, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 2'd0, 0};
    issue(v);
    serve_addr();
    m_rvalid = 1; s0_rready = 1; s0_arvalid = 1;
    #1;
    chk("pre_rst_s0_rvalid", s0_rvalid, 1'b1);
    rst = 0;
    #1;
    chk("arst_s0_rvalid", s0_rvalid, 1'b0);
    chk("arst_m_rready", m_rready, 1'b0);
    chk("arst_s0_arready", s0_arready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    m_rvalid = 0; s0_rready = 0; s0_arvalid = 0;
    tick();
    rst = 1;
    tick();
    v = '{1, 1, 0, 32'h0000_5000, 32'h0000_5100, 32'h0, 32'h0, 4'h0, 32'h0, 2'd0, 0};
    issue(v);
    serve_addr();
    serve_data(0, 32'h5555_AAAA, 2'd0);

    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
